// File: rtl/disp_pkg.sv
// ============================================================================
// disp_pkg : shared types and constants for the seven-segment display blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

  localparam int         NDIG    = 8;
  localparam logic [7:0] SEG_OFF = 8'hFF;

  typedef logic [7:0] seg_t;
  typedef logic [2:0] dig_idx_t;

  // Active-low anode pattern selecting a single digit.
  function automatic logic [7:0] an_onehot_low(input dig_idx_t idx);
    return ~(8'b1 << idx);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dim_pwm.sv
// ============================================================================
// dim_pwm : 4-bit free-running dimming counter, gate high while count <= bright
// Rev 1.0
// ============================================================================
`default_nettype none

module dim_pwm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bright,
  output logic       gate
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // bright = 15 keeps the gate permanently open; bright = 0 gives 1/16 duty.
  assign gate = en && (cnt_q <= bright);

endmodule

`default_nettype wire

// File: rtl/seg_scan_mux8.sv
// ============================================================================
// seg_scan_mux8 : 8-digit seven-segment scanner with per-frame snapshot and
//                 16-level PWM dimming. Optional macro: SEG_SCAN_GHOST_GUARD_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module seg_scan_mux8
  import disp_pkg::*;
#(
  parameter int DWELL = 50_000,
  parameter int GUARD = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] bright,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  output logic [7:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int             SW        = $clog2(DWELL);
  localparam logic [SW-1:0]  SLOT_LAST = SW'(DWELL - 1);

  generate
    if (DWELL < 16 || GUARD >= DWELL) begin : g_param_check
      $error("seg_scan_mux8: need DWELL >= 16 and GUARD < DWELL");
    end
  endgenerate

  logic [SW-1:0] slot_cnt_q, slot_cnt_d;
  dig_idx_t      idx_q, idx_d;
  logic          load_pend_q, load_pend_d;
  logic          frame_tick_q, frame_tick_d;
  seg_t          an_q, an_d;
  seg_t          sseg_q, sseg_d;
  seg_t          shadow_q [NDIG];
  seg_t          shadow_d [NDIG];
  seg_t          in_w     [NDIG];

  logic          pwm_gate;
  logic          guard_ok;
  logic          lit;
  logic          slot_end;
  logic          capture;

  assign in_w = '{in0, in1, in2, in3, in4, in5, in6, in7};

  dim_pwm u_dim_pwm (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .bright (bright),
    .gate   (pwm_gate)
  );

`ifdef SEG_SCAN_GHOST_GUARD_EN
  assign guard_ok = (slot_cnt_q >= SW'(GUARD));
`else
  assign guard_ok = 1'b1;
`endif

  assign lit      = pwm_gate && guard_ok;
  assign slot_end = (slot_cnt_q == SLOT_LAST);
  // A frame boundary is the last cycle of digit 7; the pending flag forces
  // an immediate snapshot after reset so stale shadows never reach the bus.
  assign capture  = en && (load_pend_q || (slot_end && idx_q == 3'd7));

  always_comb begin
    slot_cnt_d   = slot_cnt_q;
    idx_d        = idx_q;
    load_pend_d  = load_pend_q;
    shadow_d     = shadow_q;
    frame_tick_d = 1'b0;

    if (en) begin
      if (slot_end) begin
        slot_cnt_d = '0;
        idx_d      = idx_q + 3'd1;
      end else begin
        slot_cnt_d = slot_cnt_q + 1'b1;
      end
    end

    if (capture) begin
      shadow_d     = in_w;
      load_pend_d  = 1'b0;
      frame_tick_d = 1'b1;
    end
  end

  always_comb begin
    an_d   = SEG_OFF;
    sseg_d = SEG_OFF;
    if (lit) begin
      an_d   = an_onehot_low(idx_q);
      sseg_d = shadow_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt_q   <= '0;
      idx_q        <= '0;
      load_pend_q  <= 1'b1;
      frame_tick_q <= 1'b0;
      an_q         <= SEG_OFF;
      sseg_q       <= SEG_OFF;
      for (int k = 0; k < NDIG; k++) begin
        shadow_q[k] <= SEG_OFF;
      end
    end else begin
      slot_cnt_q   <= slot_cnt_d;
      idx_q        <= idx_d;
      load_pend_q  <= load_pend_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      shadow_q     <= shadow_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = frame_tick_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux8.sv
// ============================================================================
// tb_seg_scan_mux8 : randomized self-checking bench against a cycle-count model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg_scan_mux8;

  localparam int DW   = 20;
  localparam int GD   = 4;
  localparam int FRM  = 8 * DW;
`ifdef SEG_SCAN_GHOST_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] bright;
  logic [7:0] tin [8];
  logic [7:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: number of enabled cycles since reset fully determines the
  // slot position, digit index and dimming phase.
  int         e_cnt;
  bit         pend;
  logic [7:0] sh [8];
  logic [7:0] exp_an, exp_sseg;
  logic       exp_ft;

  always #5 clk = ~clk;

  seg_scan_mux8 #(.DWELL(DW), .GUARD(GD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bright     (bright),
    .in0        (tin[0]),
    .in1        (tin[1]),
    .in2        (tin[2]),
    .in3        (tin[3]),
    .in4        (tin[4]),
    .in5        (tin[5]),
    .in6        (tin[6]),
    .in7        (tin[7]),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic int cur_pos();
    return e_cnt % DW;
  endfunction

  function automatic int cur_idx();
    return (e_cnt / DW) % 8;
  endfunction

  task automatic model_edge();
    int  pos, idx, pwm;
    bit  lit;
    if (!rst_n) begin
      e_cnt = 0; pend = 1'b1;
      for (int k = 0; k < 8; k++) sh[k] = 8'hFF;
      exp_an = 8'hFF; exp_sseg = 8'hFF; exp_ft = 1'b0;
    end else if (!en) begin
      exp_an = 8'hFF; exp_sseg = 8'hFF; exp_ft = 1'b0;
    end else begin
      pos = cur_pos();
      idx = cur_idx();
      pwm = e_cnt % 16;
      lit = (pwm <= int'(bright)) && (!GUARD_ON || pos >= GD);
      exp_an   = lit ? 8'(~(32'd1 << idx)) : 8'hFF;
      exp_sseg = lit ? sh[idx] : 8'hFF;
      exp_ft   = pend || ((e_cnt % FRM) == FRM - 1);
      if (exp_ft) begin
        for (int k = 0; k < 8; k++) sh[k] = tin[k];
        pend = 1'b0;
      end
      e_cnt++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an", an, exp_an);
    check("sseg", sseg, exp_sseg);
    check("frame_tick", {7'd0, frame_tick}, {7'd0, exp_ft});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idx(input int want);
    int i;
    for (i = 0; i < 2 * FRM && cur_idx() != want; i++) step();
    check("reach_idx", 8'(cur_idx()), 8'(want));
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; bright = 4'd0;
    for (int k = 0; k < 8; k++) tin[k] = 8'hFF;
    tin[0] = 8'h9C;

    // Reset and first frame
    run(3);
    rst_n = 1'b1; en = 1'b1; bright = 4'd15;
    run(200);

    // Scan order with a recognisable pattern per digit
    for (int k = 0; k < 8; k++) tin[k] = 8'(k * 8'h11);
    run(2 * FRM);

    // Tear-free update: in3 changes while digit 1 is showing
    run_until_idx(1);
    tin[3] = 8'h5A;
    run(2 * FRM);

    // Brightness levels
    bright = 4'd3;  run(FRM);
    bright = 4'd0;  run(FRM);
    bright = 4'd15; run(40);

    // Enable hold at slot position 7
    for (int i = 0; i < DW && cur_pos() != 7; i++) step();
    check("reach_pos7", 8'(cur_pos()), 8'd7);
    en = 1'b0; run(50);
    en = 1'b1; run(60);

    // Mid-frame reset during digit 5
    run_until_idx(5);
    rst_n = 1'b0; run(2);
    rst_n = 1'b1; run(200);

    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 36) == 0) bright = 4'($urandom_range(0, 15));
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 19) == 0) tin[k] = 8'($urandom);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
